// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_pkg
// Description : Shared widths, requester IDs and arbiter state encoding for
//               the grid RAM arbiter and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_pkg;

   localparam int GRID_X_W = 6;
   localparam int GRID_Y_W = 5;
   localparam int GRID_D_W = 3;

   // Default requester assignment
   localparam int REQ_LL = 0;   // level loader
   localparam int REQ_DG = 1;   // grid drawer
   localparam int REQ_RT = 2;   // raytracer

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } grid_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or above ptr_i, wrapping to bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  win_o,
   output logic          valid_o
);

   logic [N-1:0] ge_mask;
   logic [N-1:0] upper;
   logic [N-1:0] pool;

   // Mask of positions at or above the search start
   always_comb begin
      for (int i = 0; i < N; i++) begin
         ge_mask[i] = (i >= int'(ptr_i));
      end
   end

   // Prefer requests above the pointer; fall back to the wrapped set,
   // then isolate the lowest set bit of the chosen pool.
   assign upper   = req_i & ge_mask;
   assign pool    = (|upper) ? upper : req_i;
   assign win_o   = pool & (~pool + N'(1));
   assign valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/grid_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grid_arbiter
// Description : Round-robin req/gnt arbiter sharing the single-port grid RAM
//               among NREQ requesters, with burst lock, optional hold limit
//               and per-requester read-data tagging.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_arbiter
   import grid_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int MAX_HOLD = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_i,
   input  logic [NREQ-1:0]            lock_i,
   input  logic [NREQ*GRID_X_W-1:0]   req_x_i,
   input  logic [NREQ*GRID_Y_W-1:0]   req_y_i,
   input  logic [NREQ-1:0]            req_write_i,
   input  logic [NREQ*GRID_D_W-1:0]   req_in_i,
   output logic [NREQ-1:0]            gnt_o,
   output logic [NREQ-1:0]            rvalid_o,
   output logic [GRID_X_W-1:0]        grid_x_o,
   output logic [GRID_Y_W-1:0]        grid_y_o,
   output logic                       grid_write_o,
   output logic [GRID_D_W-1:0]        grid_in_o,
   output logic                       busy_o
);

   localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam bit HOLD_EN   = (MAX_HOLD > 0);

   grid_state_t     state_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] rvalid_q;
   logic [IW-1:0]   hold_q;    // index of the current holder
   logic [IW-1:0]   ptr_q;     // first index searched: one past the last holder
   logic [CW-1:0]   cnt_q;     // accesses by the holder, modulo MAX_HOLD

   logic [GRID_X_W-1:0] fx   [NREQ];
   logic [GRID_Y_W-1:0] fy   [NREQ];
   logic [GRID_D_W-1:0] fd   [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_fields
      assign fx[g] = req_x_i[g*GRID_X_W +: GRID_X_W];
      assign fy[g] = req_y_i[g*GRID_Y_W +: GRID_Y_W];
      assign fd[g] = req_in_i[g*GRID_D_W +: GRID_D_W];
   end

   logic            granted;
   logic            access;
   logic [NREQ-1:0] others;
   logic            rotate;
   logic            change;
   logic [NREQ-1:0] pick_req;
   logic [NREQ-1:0] win;
   logic            win_valid;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   ptr_after;

   assign granted = (state_q == ST_GRANTED);
   assign access  = granted & req_i[hold_q];
   assign others  = req_i & ~gnt_q;

   // Forced rotation on the last allowed access, unless locked or alone
   assign rotate  = HOLD_EN & access & ~lock_i[hold_q] & (|others)
                  & (cnt_q == CW'(HOLD_LAST));

   // Re-arbitrate when idle, when the holder releases, or on rotation
   assign change   = ~access | rotate;
   assign pick_req = rotate ? others : req_i;

   rr_pick #(
      .N (NREQ),
      .PW(IW)
   ) u_pick (
      .req_i  (pick_req),
      .ptr_i  (ptr_q),
      .win_o  (win),
      .valid_o(win_valid)
   );

   // Convert the one-hot winner into an index
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) win_idx = IW'(i);
      end
   end

   assign ptr_after = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

   // Grant state machine: grant, release, rotation and read tagging
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
         hold_q   <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         rvalid_q <= (access && !req_write_i[hold_q]) ? gnt_q : '0;
         if (change) begin
            cnt_q <= '0;
            if (win_valid) begin
               state_q <= ST_GRANTED;
               gnt_q   <= win;
               hold_q  <= win_idx;
               ptr_q   <= ptr_after;
            end else begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
            end
         end else if (HOLD_EN) begin
            cnt_q <= (cnt_q == CW'(HOLD_LAST)) ? '0 : cnt_q + CW'(1);
         end
      end
   end

   assign gnt_o        = gnt_q;
   assign rvalid_o     = rvalid_q;
   assign busy_o       = |gnt_q;
   assign grid_x_o     = granted ? fx[hold_q] : '0;
   assign grid_y_o     = granted ? fy[hold_q] : '0;
   assign grid_in_o    = granted ? fd[hold_q] : '0;
   assign grid_write_o = access & req_write_i[hold_q] & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_grid_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_arbiter
// Description : Scoreboard bench for grid_arbiter with a behavioural grid RAM
//               and a cycle-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_arbiter;
   import grid_pkg::*;

   localparam int N  = 3;
   localparam int MH = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req, lock, wr;
   logic [5:0]     fx [N];
   logic [4:0]     fy [N];
   logic [2:0]     fd [N];
   logic [N*6-1:0] req_x;
   logic [N*5-1:0] req_y;
   logic [N*3-1:0] req_in;
   logic [N-1:0]   gnt, rvalid;
   logic [5:0]     grid_x;
   logic [4:0]     grid_y;
   logic           grid_write;
   logic [2:0]     grid_in;
   logic           busy;

   assign req_x  = {fx[2], fx[1], fx[0]};
   assign req_y  = {fy[2], fy[1], fy[0]};
   assign req_in = {fd[2], fd[1], fd[0]};

   grid_arbiter #(
      .NREQ    (N),
      .MAX_HOLD(MH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_i       (req),
      .lock_i      (lock),
      .req_x_i     (req_x),
      .req_y_i     (req_y),
      .req_write_i (wr),
      .req_in_i    (req_in),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .grid_x_o    (grid_x),
      .grid_y_o    (grid_y),
      .grid_write_o(grid_write),
      .grid_in_o   (grid_in),
      .busy_o      (busy)
   );

   always #5 clock = ~clock;

   // Grid RAM: 64x32 cells, synchronous read, preload pattern on ram_fill
   logic [2:0] mem [64][32];
   logic [2:0] grid_out;
   logic       ram_fill;
   always @(posedge clock) begin
      if (ram_fill) begin
         for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
               mem[x][y] <= 3'(x + y + (x >> 3));
      end else if (grid_write) begin
         mem[grid_x][grid_y] <= grid_in;
      end
      grid_out <= mem[grid_x][grid_y];
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard of expected tagged reads
   typedef struct {
      int idx;
      int data;
      int cyc;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   // Monitor: every rvalid must match the oldest expected read
   always @(negedge clock) begin
      if (rvalid !== '0) begin
         if (sbq.size() == 0) begin
            chk("rvalid_spurious", rvalid, 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("rvalid_tag", rvalid, 1 << mon_e.idx);
            chk("rvalid_data", grid_out, mon_e.data);
            chk("rvalid_cycle", cyc, mon_e.cyc);
         end
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         mon_e = sbq.pop_front();
         chk("rvalid_missing", rvalid, 1 << mon_e.idx);
      end
   end

   // Reference model: holder (-1 = none), last holder, accesses since grant
   logic [2:0] ref_mem [64][32];
   int m_h    = -1;
   int m_last = N - 1;
   int m_cnt  = 0;

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // One clock cycle with the inputs currently applied
   task automatic step();
      int ex, ey, ed, ew, w;
      logic [N-1:0] oth;
      #1;
      if (reset) begin
         chk("grid_write_in_reset", grid_write, 0);
      end else begin
         if (m_h >= 0) begin
            ex = fx[m_h]; ey = fy[m_h]; ed = fd[m_h];
            ew = req[m_h] & wr[m_h];
         end else begin
            ex = 0; ey = 0; ed = 0; ew = 0;
         end
         chk("grid_x", grid_x, ex);
         chk("grid_y", grid_y, ey);
         chk("grid_in", grid_in, ed);
         chk("grid_write", grid_write, ew);
      end

      if (reset) begin
         m_h = -1; m_last = N - 1; m_cnt = 0;
      end else if (m_h < 0) begin
         w = pick(req, m_last);
         if (w >= 0) begin m_h = w; m_last = w; m_cnt = 0; end
      end else if (!req[m_h]) begin
         w = pick(req, m_last);
         m_h = w;
         if (w >= 0) m_last = w;
         m_cnt = 0;
      end else begin
         if (wr[m_h]) ref_mem[fx[m_h]][fy[m_h]] = fd[m_h];
         else sbq.push_back('{idx: m_h, data: int'(ref_mem[fx[m_h]][fy[m_h]]), cyc: cyc + 1});
         oth = req;
         oth[m_h] = 1'b0;
         if (!lock[m_h] && oth != '0 && (m_cnt % MH) == MH - 1) begin
            w = pick(oth, m_last);
            m_h = w; m_last = w; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end

      @(posedge clock);
      #1;
      chk("gnt", gnt, (m_h < 0) ? 0 : (1 << m_h));
      chk("busy", busy, m_h >= 0);
   endtask

   task automatic set_field(input int i, input int x, input int y, input int d);
      fx[i] = 6'(x); fy[i] = 5'(y); fd[i] = 3'(d);
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; lock = '0; wr = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      for (int x = 0; x < 64; x++)
         for (int y = 0; y < 32; y++)
            ref_mem[x][y] = 3'(x + y + (x >> 3));
      for (int i = 0; i < N; i++) set_field(i, i + 1, i + 2, i);
      ram_fill = 1'b1;
      do_reset();
      ram_fill = 1'b0;
      chk("reset_gnt", gnt, 0);
      chk("reset_rvalid", rvalid, 0);
      chk("reset_busy", busy, 0);
      step();

      // All three request; drop them one by one, no idle gap expected
      req = 3'b111;
      step(); step();
      req = 3'b110; step();
      req = 3'b100; step(); step();
      req = 3'b000; step(); step();

      // Raytracer alone reads (5,7)
      set_field(REQ_RT, 5, 7, 0);
      req = 3'b100; step(); step();
      req = 3'b000; step(); step();

      // Loader writes (63,31)=6; drawer drives a write with no request
      set_field(REQ_LL, 63, 31, 6);
      set_field(REQ_DG, 1, 1, 7);
      wr = 3'b011; req = 3'b001; step(); step();
      wr = 3'b000; step(); step();
      req = 3'b000; step(); step();

      // Hold limit rotation without lock
      do_reset();
      req = 3'b011;
      for (int k = 0; k < 12; k++) step();

      // Lock keeps requester 0 beyond the limit, then rotation resumes
      do_reset();
      lock = 3'b001;
      req = 3'b011;
      for (int k = 0; k < 14; k++) step();
      lock = 3'b000;
      for (int k = 0; k < 8; k++) step();

      // Reset in the middle of a read burst
      req = 3'b111; lock = '0;
      step(); step(); step();
      reset = 1'b1; step();
      chk("gnt_after_reset", gnt, 0);
      chk("rvalid_after_reset", rvalid, 0);
      reset = 1'b0; req = 3'b111; step();

      // Randomised traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 2) == 0) req = 3'($urandom_range(0, 7));
         lock  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         wr    = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < N; i++)
            set_field(i, $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 7));
         step();
      end
      reset = 1'b0; req = '0; lock = '0; wr = '0;

      // Final read-back of (63,31) by the loader, then drain
      set_field(REQ_LL, 63, 31, 0);
      req = 3'b001; step(); step();
      req = 3'b000;
      for (int k = 0; k < 4; k++) step();
      chk("scoreboard_drained", sbq.size(), 0);

      begin
         int mism;
         mism = 0;
         for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
               if (mem[x][y] !== ref_mem[x][y]) mism++;
         chk("ram_image_mismatches", mism, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
